cmd_sched: RTL and testbench

Round-robin command scheduler that shares one command engine (start/ready/done handshake, 2-bit command CMD_A..CMD_D) among NREQ requesters. It arbitrates pending requests and issues a one-cycle start with the winning command. It then waits for the engine's done and returns per-requester ack, done and timeout-error pulses. It sits between the requesting agents and the engine, and is the only driver of the engine's start/cmd inputs.

---
 rtl/cmd_sched_if.sv | 29 ++
 rtl/cmd_sched.sv | 164 ++++++++++++++++
 tb/tb_cmd_sched.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/cmd_sched_if.sv
// Request/engine bundle between the requesting agents, the scheduler and the command engine.
// Latency: none (wires only).
// Backpressure: req_valid is held until req_ack; the engine throttles starts through eng_ready.
//   master: scheduler side (drives ack/done/err pulses, eng_start, eng_cmd, busy)
//   slave : agents plus engine side (drives req_valid, req_cmd, eng_ready, eng_done)
interface cmd_sched_if #(
    parameter int NREQ = 4
) ();
    logic [NREQ-1:0]   req_valid;
    logic [2*NREQ-1:0] req_cmd;
    logic [NREQ-1:0]   req_ack;
    logic [NREQ-1:0]   req_done;
    logic [NREQ-1:0]   req_err;
    logic              eng_start;
    logic [1:0]        eng_cmd;
    logic              eng_ready;
    logic              eng_done;
    logic              busy;

    modport master (
        input  req_valid, req_cmd, eng_ready, eng_done,
        output req_ack, req_done, req_err, eng_start, eng_cmd, busy
    );

    modport slave (
        output req_valid, req_cmd, eng_ready, eng_done,
        input  req_ack, req_done, req_err, eng_start, eng_cmd, busy
    );
endinterface

// File: rtl/cmd_sched.sv
// Round-robin scheduler sharing one command engine among NREQ requesters.
// Latency: start/ack one cycle after arbitration; done/err one cycle after engine done or timeout.
// Backpressure: no arbitration while eng_ready is low or a command is outstanding (one in flight).
//   ports: clk, rstn (async active-low), bus (cmd_sched_if.master: requests, engine handshake, busy)
//   all outputs are registered; eng_cmd holds the last issued command until the next grant.
module cmd_sched #(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rstn,
    cmd_sched_if.master bus
);
    localparam int IW = $clog2(NREQ);
    localparam int CW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [IW-1:0]     ptr_q, ptr_d;
    logic [IW-1:0]     win_q, win_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [1:0]        eng_cmd_q, eng_cmd_d;
    logic [NREQ-1:0]   req_ack_q, req_ack_d;
    logic [NREQ-1:0]   req_done_q, req_done_d;
    logic [NREQ-1:0]   req_err_q, req_err_d;
    logic              eng_start_q, eng_start_d;
    logic              busy_q, busy_d;

    // Arbitration results
    logic [NREQ-1:0]   rot;
    logic              arb_found;
    logic [IW-1:0]     arb_win;
    logic [1:0]        arb_cmd;
    logic [IW:0]       arb_sum;
    logic [IW:0]       ptr_inc;
    logic [IW-1:0]     ptr_next;

    function automatic logic [NREQ-1:0] onehot(input logic [IW-1:0] idx);
        return {{(NREQ-1){1'b0}}, 1'b1} << idx;
    endfunction

    // Rotate the request vector so bit 0 is the requester at ptr; the first
    // set bit is then the round-robin winner, offset back by ptr.
    always_comb begin
        rot       = NREQ'({bus.req_valid, bus.req_valid} >> ptr_q);
        arb_found = 1'b0;
        arb_win   = '0;
        arb_sum   = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!arb_found && rot[k]) begin
                arb_found = 1'b1;
                arb_sum   = {1'b0, ptr_q} + (IW+1)'(k);
                if (arb_sum >= (IW+1)'(NREQ)) begin
                    arb_sum = arb_sum - (IW+1)'(NREQ);
                end
                arb_win = arb_sum[IW-1:0];
            end
        end
    end

    always_comb begin
        arb_cmd = 2'b00;
        for (int k = 0; k < NREQ; k++) begin
            if (arb_win == IW'(k)) begin
                arb_cmd = bus.req_cmd[2*k +: 2];
            end
        end
    end

    // Pointer moves to the requester just after the one that finished.
    always_comb begin
        ptr_inc  = {1'b0, win_q} + (IW+1)'(1);
        ptr_next = (ptr_inc == (IW+1)'(NREQ)) ? '0 : ptr_inc[IW-1:0];
    end

    // Next-state and registered-output values
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        win_d       = win_q;
        cnt_d       = cnt_q;
        eng_cmd_d   = eng_cmd_q;
        req_ack_d   = '0;
        req_done_d  = '0;
        req_err_d   = '0;
        eng_start_d = 1'b0;
        busy_d      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.eng_ready && arb_found) begin
                    state_d     = S_START;
                    win_d       = arb_win;
                    eng_cmd_d   = arb_cmd;
                    req_ack_d   = onehot(arb_win);
                    eng_start_d = 1'b1;
                    busy_d      = 1'b1;
                end
            end
            S_START: begin
                // eng_done is deliberately not looked at here.
                state_d = S_WAIT;
                cnt_d   = '0;
                busy_d  = 1'b1;
            end
            S_WAIT: begin
                // done is tested first so it wins over a coincident timeout.
                if (bus.eng_done) begin
                    state_d    = S_IDLE;
                    req_done_d = onehot(win_q);
                    ptr_d      = ptr_next;
                end else if (cnt_q == CW'(TIMEOUT-1)) begin
                    state_d   = S_IDLE;
                    req_err_d = onehot(win_q);
                    ptr_d     = ptr_next;
                end else begin
                    cnt_d  = cnt_q + CW'(1);
                    busy_d = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= S_IDLE;
            ptr_q       <= '0;
            win_q       <= '0;
            cnt_q       <= '0;
            eng_cmd_q   <= 2'b00;
            req_ack_q   <= '0;
            req_done_q  <= '0;
            req_err_q   <= '0;
            eng_start_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            win_q       <= win_d;
            cnt_q       <= cnt_d;
            eng_cmd_q   <= eng_cmd_d;
            req_ack_q   <= req_ack_d;
            req_done_q  <= req_done_d;
            req_err_q   <= req_err_d;
            eng_start_q <= eng_start_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.req_ack   = req_ack_q;
    assign bus.req_done  = req_done_q;
    assign bus.req_err   = req_err_q;
    assign bus.eng_start = eng_start_q;
    assign bus.eng_cmd   = eng_cmd_q;
    assign bus.busy      = busy_q;
endmodule

// File: tb/tb_cmd_sched.sv
// Bench for cmd_sched: directed stimulus pushes expected start/done/err events
// (with hand-computed cycle numbers) into a scoreboard; a negedge monitor pops
// and compares whenever the DUT pulses an output.
module tb_cmd_sched;
    localparam int NREQ    = 4;
    localparam int TIMEOUT = 8;

    localparam int EV_START = 0;
    localparam int EV_DONE  = 1;
    localparam int EV_ERR   = 2;

    typedef struct {
        int       kind;
        int       idx;
        logic [1:0] cmd;
        int       at;
    } exp_t;

    logic clk = 1'b0;
    logic rstn;
    int   cyc   = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    bit   mon_en = 1'b0;
    exp_t sb[$];
    exp_t mon_e;
    int   mon_kind;
    logic [1:0] cur_cmd = 2'b00;
    int   c;

    cmd_sched_if #(.NREQ(NREQ)) bus ();

    cmd_sched #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic void expect_ev(input int kind, input int idx, input logic [1:0] cmd, input int at);
        exp_t e;
        e.kind = kind;
        e.idx  = idx;
        e.cmd  = cmd;
        e.at   = at;
        sb.push_back(e);
    endfunction

    // Monitor
    always @(negedge clk) begin
        if (mon_en) begin
            while (sb.size() != 0 && sb[0].at < cyc) begin
                mon_e = sb.pop_front();
                n_cmp++;
                n_bad++;
                $display("FAIL missing_event: got nothing, expected kind %0d idx %0d at cycle %0d",
                         mon_e.kind, mon_e.idx, mon_e.at);
            end
            if (bus.eng_start || (|bus.req_ack) || (|bus.req_done) || (|bus.req_err)) begin
                mon_kind = (bus.req_err != '0) ? EV_ERR :
                           (bus.req_done != '0) ? EV_DONE : EV_START;
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_event: got kind %0d at cycle %0d, expected none",
                             mon_kind, cyc);
                end else begin
                    mon_e = sb.pop_front();
                    chk("event_cycle", 32'(cyc), 32'(mon_e.at));
                    chk("event_kind", 32'(mon_kind), 32'(mon_e.kind));
                    case (mon_e.kind)
                        EV_START: begin
                            chk("req_ack", 32'(bus.req_ack), 32'(1) << mon_e.idx);
                            chk("eng_start", 32'(bus.eng_start), 32'(1));
                            chk("eng_cmd_at_start", 32'(bus.eng_cmd), 32'(mon_e.cmd));
                            chk("busy_at_start", 32'(bus.busy), 32'(1));
                            cur_cmd = mon_e.cmd;
                        end
                        EV_DONE: begin
                            chk("req_done", 32'(bus.req_done), 32'(1) << mon_e.idx);
                            chk("req_err_at_done", 32'(bus.req_err), 32'(0));
                            chk("req_ack_at_done", 32'(bus.req_ack), 32'(0));
                            chk("busy_at_done", 32'(bus.busy), 32'(0));
                        end
                        default: begin
                            chk("req_err", 32'(bus.req_err), 32'(1) << mon_e.idx);
                            chk("req_done_at_err", 32'(bus.req_done), 32'(0));
                            chk("req_ack_at_err", 32'(bus.req_ack), 32'(0));
                            chk("busy_at_err", 32'(bus.busy), 32'(0));
                        end
                    endcase
                end
            end
            if (bus.busy && !bus.eng_start) begin
                chk("eng_cmd_hold", 32'(bus.eng_cmd), 32'(cur_cmd));
            end
        end
    end

    initial begin
        rstn          = 1'b0;
        bus.req_valid = '0;
        bus.req_cmd   = '0;
        bus.eng_ready = 1'b0;
        bus.eng_done  = 1'b0;
        tick(2);

        // Reset values
        chk("rst_eng_start", 32'(bus.eng_start), 32'(0));
        chk("rst_req_ack", 32'(bus.req_ack), 32'(0));
        chk("rst_req_done", 32'(bus.req_done), 32'(0));
        chk("rst_req_err", 32'(bus.req_err), 32'(0));
        chk("rst_busy", 32'(bus.busy), 32'(0));
        chk("rst_eng_cmd", 32'(bus.eng_cmd), 32'(0));
        rstn   = 1'b1;
        mon_en = 1'b1;
        tick(2);

        // Round robin, all valid, done returned in the first WAIT cycle
        c = cyc;
        bus.req_valid = 4'b1111;
        bus.req_cmd   = 8'hE4;
        bus.eng_ready = 1'b1;
        bus.eng_done  = 1'b1;
        for (int k = 0; k < 5; k++) begin
            expect_ev(EV_START, k % 4, 2'(k % 4), c + 1 + 3*k);
            expect_ev(EV_DONE,  k % 4, 2'b00,     c + 3 + 3*k);
        end
        tick(15);
        bus.req_valid = '0;
        bus.eng_done  = 1'b0;
        tick(3);

        // Single request (ptr now 1, wraps to 0); req_cmd changes after grant
        c = cyc;
        bus.req_valid = 4'b0001;
        bus.req_cmd   = 8'h01;
        expect_ev(EV_START, 0, 2'b01, c + 1);
        expect_ev(EV_DONE,  0, 2'b00, c + 7);
        tick(1);
        bus.req_valid = '0;
        bus.req_cmd   = 8'hFF;
        tick(5);
        bus.eng_done = 1'b1;
        tick(1);
        bus.eng_done = 1'b0;
        tick(2);

        // Engine not ready for 5 cycles; requester 2 withdraws before grant
        c = cyc;
        bus.eng_ready = 1'b0;
        bus.req_valid = 4'b0110;
        bus.req_cmd   = 8'h38;
        tick(5);
        bus.eng_ready = 1'b1;
        expect_ev(EV_START, 1, 2'b10, c + 6);
        expect_ev(EV_DONE,  1, 2'b00, c + 8);
        tick(1);
        bus.req_valid = 4'b0100;
        tick(1);
        bus.eng_done  = 1'b1;
        bus.req_valid = '0;
        tick(1);
        bus.eng_done = 1'b0;
        tick(3);

        // Done only in START is ignored; command then times out
        c = cyc;
        bus.req_valid = 4'b1000;
        bus.req_cmd   = 8'h40;
        expect_ev(EV_START, 3, 2'b01, c + 1);
        expect_ev(EV_ERR,   3, 2'b00, c + 1 + TIMEOUT + 1);
        tick(1);
        bus.req_valid = '0;
        bus.eng_done  = 1'b1;
        tick(1);
        bus.eng_done = 1'b0;
        tick(8);
        tick(2);

        // Pointer advanced past 3 -> 0 wins over 3; done on final timeout cycle
        c = cyc;
        bus.req_valid = 4'b1001;
        bus.req_cmd   = 8'hC2;
        expect_ev(EV_START, 0, 2'b10, c + 1);
        expect_ev(EV_DONE,  0, 2'b00, c + 10);
        tick(1);
        bus.req_valid = 4'b1000;
        tick(8);
        bus.eng_done = 1'b1;
        tick(1);
        bus.eng_done  = 1'b0;
        bus.req_valid = '0;
        tick(2);

        // Reset during WAIT: no pulse for the aborted command
        c = cyc;
        bus.req_valid = 4'b0010;
        bus.req_cmd   = 8'h0C;
        expect_ev(EV_START, 1, 2'b11, c + 1);
        tick(1);
        bus.req_valid = '0;
        tick(2);
        #2;
        rstn = 1'b0;
        #1;
        chk("abort_busy", 32'(bus.busy), 32'(0));
        chk("abort_eng_cmd", 32'(bus.eng_cmd), 32'(0));
        chk("abort_eng_start", 32'(bus.eng_start), 32'(0));
        bus.eng_done = 1'b1;
        tick(2);
        bus.eng_done = 1'b0;
        rstn = 1'b1;
        tick(3);

        // After reset the pointer is back at 0
        c = cyc;
        bus.req_valid = 4'b1111;
        bus.req_cmd   = 8'hE5;
        bus.eng_done  = 1'b1;
        expect_ev(EV_START, 0, 2'b01, c + 1);
        expect_ev(EV_DONE,  0, 2'b00, c + 3);
        tick(1);
        bus.req_valid = '0;
        tick(2);
        bus.eng_done = 1'b0;
        tick(4);

        mon_en = 1'b0;
        while (sb.size() != 0) begin
            mon_e = sb.pop_front();
            n_cmp++;
            n_bad++;
            $display("FAIL leftover_event: got nothing, expected kind %0d idx %0d at cycle %0d",
                     mon_e.kind, mon_e.idx, mon_e.at);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
